glove_conditioner: RTL

Per-glove input conditioner that converts raw sensor samples (position in mm, open/closed bit) into the clean glove signals the ball state machine consumes: filtered glove_x/glove_y, debounced glove_closed, and the can_catch arming qualifier. It sits between the glove sensor front end and the ball logic, with one instance per glove. It rejects position outliers, smooths jitter, debounces the closed bit, and withholds catch permission for a short open interval after every release, so a just-thrown ball is not re-caught.

---
 rtl/catch_pkg.sv | 17 +
 rtl/glove_conditioner_if.sv | 25 ++
 rtl/sample_debounce.sv | 41 ++++
 rtl/glove_conditioner.sv | 126 ++++++++++++
 4 files changed

// File: rtl/catch_pkg.sv
// Shared glove/ball types: position width, conditioner states and a
// magnitude helper for the signed per-axis difference.
package catch_pkg;

  localparam int unsigned MM_W   = 16;
  localparam int unsigned DIFF_W = MM_W + 1;

  typedef enum logic {
    ACQUIRE = 1'b0,
    TRACK   = 1'b1
  } glove_state_e;

  function automatic logic [DIFF_W-1:0] abs_diff(input logic signed [DIFF_W-1:0] d);
    return d[DIFF_W-1] ? DIFF_W'(-d) : DIFF_W'(d);
  endfunction

endpackage

// File: rtl/glove_conditioner_if.sv
// Sensor-to-ball-logic glove bus: raw sample strobe in, conditioned glove state out.
interface glove_conditioner_if;
  import catch_pkg::*;

  logic            sample_valid;
  logic [MM_W-1:0] raw_x;
  logic [MM_W-1:0] raw_y;
  logic            raw_closed;
  logic [MM_W-1:0] glove_x;
  logic [MM_W-1:0] glove_y;
  logic            glove_closed;
  logic            can_catch;
  logic            tracking;

  modport master (
    output sample_valid, raw_x, raw_y, raw_closed,
    input  glove_x, glove_y, glove_closed, can_catch, tracking
  );

  modport slave (
    input  sample_valid, raw_x, raw_y, raw_closed,
    output glove_x, glove_y, glove_closed, can_catch, tracking
  );

endinterface

// File: rtl/sample_debounce.sv
// Count-to-N debouncer advanced only on sample strobes; fall_c flags the
// sample that will drop level on this edge so arming can clear in step.
module sample_debounce #(
  parameter int unsigned N = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_valid,
  input  logic clear,
  input  logic raw,
  output logic level,
  output logic fall_c
);

  localparam int unsigned CW = $clog2(N + 1);

  logic [CW-1:0] cnt;
  logic          hit_c;

  assign hit_c  = sample_valid && (raw != level) && (cnt == CW'(N - 1));
  assign fall_c = hit_c && level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (sample_valid) begin
      if (raw == level) begin
        cnt <= '0;
      end else if (hit_c) begin
        level <= raw;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/glove_conditioner.sv
// Per-glove conditioner: outlier rejection, exponential smoothing, closed-bit
// debounce, post-release re-arm delay and stale-sample drop to ACQUIRE.
module glove_conditioner
  import catch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SAMPLES = 3,
  parameter int unsigned SMOOTH_SHIFT     = 2,
  parameter int unsigned MAX_JUMP_MM      = 400,
  parameter int unsigned REJECT_LIMIT     = 3,
  parameter int unsigned REARM_SAMPLES    = 4,
  parameter int unsigned STALE_CYCLES     = 6500000
) (
  input logic               clk,
  input logic               reset,
  glove_conditioner_if.slave bus
);

  localparam int unsigned SW = $clog2(STALE_CYCLES + 1);
  localparam int unsigned OW = $clog2(REARM_SAMPLES + 1);
  localparam int unsigned RW = $clog2(REJECT_LIMIT + 1);

  glove_state_e     state, state_n;
  logic [MM_W-1:0]  glove_x_q, glove_y_q;
  logic             armed, armed_n;
  logic             can_catch_q, tracking_q;
  logic [SW-1:0]    stale_cnt;
  logic [OW-1:0]    open_cnt;
  logic [RW-1:0]    reject_cnt;
  logic             glove_closed;
  logic             fall_c;
  logic             stale_c;
  logic             outlier_c;

  logic signed [DIFF_W-1:0] diff_x, diff_y, step_x, step_y;

  sample_debounce #(.N(DEBOUNCE_SAMPLES)) u_debounce (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (bus.sample_valid),
    .clear        (stale_c),
    .raw          (bus.raw_closed),
    .level        (glove_closed),
    .fall_c       (fall_c)
  );

  // Per-axis filter datapath, both axes identical.
  assign diff_x    = DIFF_W'({1'b0, bus.raw_x}) - DIFF_W'({1'b0, glove_x_q});
  assign diff_y    = DIFF_W'({1'b0, bus.raw_y}) - DIFF_W'({1'b0, glove_y_q});
  assign step_x    = diff_x >>> SMOOTH_SHIFT;
  assign step_y    = diff_y >>> SMOOTH_SHIFT;
  assign outlier_c = (abs_diff(diff_x) > DIFF_W'(MAX_JUMP_MM)) ||
                     (abs_diff(diff_y) > DIFF_W'(MAX_JUMP_MM));
  assign stale_c   = !bus.sample_valid && (stale_cnt == SW'(STALE_CYCLES - 1));

  // A sample in the stale cycle suppresses the drop because stale_c needs !sample_valid.
  always_comb begin
    state_n = state;
    armed_n = armed;
    if (stale_c) begin
      state_n = ACQUIRE;
      armed_n = 1'b0;
    end else if (bus.sample_valid) begin
      state_n = TRACK;
      if (fall_c) begin
        armed_n = 1'b0;
      end else if (!glove_closed && (open_cnt == OW'(REARM_SAMPLES - 1))) begin
        armed_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ACQUIRE;
      armed       <= 1'b0;
      can_catch_q <= 1'b0;
      tracking_q  <= 1'b0;
      glove_x_q   <= '0;
      glove_y_q   <= '0;
      stale_cnt   <= '0;
      open_cnt    <= '0;
      reject_cnt  <= '0;
    end else begin
      state       <= state_n;
      armed       <= armed_n;
      can_catch_q <= (state_n == TRACK) && armed_n;
      tracking_q  <= (state_n == TRACK);

      if (bus.sample_valid || stale_c) stale_cnt <= '0;
      else                             stale_cnt <= stale_cnt + SW'(1);

      if (stale_c || fall_c) begin
        open_cnt <= '0;
      end else if (bus.sample_valid && !glove_closed && (open_cnt != OW'(REARM_SAMPLES))) begin
        open_cnt <= open_cnt + OW'(1);
      end

      if (bus.sample_valid) begin
        if (state == ACQUIRE) begin
          glove_x_q  <= bus.raw_x;
          glove_y_q  <= bus.raw_y;
          reject_cnt <= '0;
        end else if (outlier_c) begin
          if (reject_cnt == RW'(REJECT_LIMIT - 1)) begin
            glove_x_q  <= bus.raw_x;
            glove_y_q  <= bus.raw_y;
            reject_cnt <= '0;
          end else begin
            reject_cnt <= reject_cnt + RW'(1);
          end
        end else begin
          glove_x_q  <= MM_W'(DIFF_W'(glove_x_q) + DIFF_W'(step_x));
          glove_y_q  <= MM_W'(DIFF_W'(glove_y_q) + DIFF_W'(step_y));
          reject_cnt <= '0;
        end
      end
    end
  end

  assign bus.glove_x      = glove_x_q;
  assign bus.glove_y      = glove_y_q;
  assign bus.glove_closed = glove_closed;
  assign bus.can_catch    = can_catch_q;
  assign bus.tracking     = tracking_q;

endmodule
